// File: rtl/pattern_scan_pkg.sv
// Shared encodings for the serial 10110 pattern scanner: detector states,
// controller states and the pattern length.
package pattern_scan_pkg;

    localparam int PAT_LEN = 5;

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } det_state_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } ctrl_state_e;

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Word-in / count-out handshake bundle of pattern_scan_ctrl; the slave modport
// is the scanner side, the master modport the producer/consumer side.
interface pattern_scan_ctrl_if #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              out_hit;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_count, out_hit
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_count, out_hit
    );
endinterface

// File: rtl/pattern_scan_ctrl_det_core.sv
// Bit-serial 10110 detector: overlapping Mealy FSM with a registered match
// pulse that is forced low on any cycle the core is not enabled.
module pattern_det_core
    import pattern_scan_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic       bit_in,
    output logic       match,
    output logic [2:0] state
);

    localparam det_state_e LAST_S = det_state_e'(3'(PAT_LEN - 1));

    det_state_e state_q;
    det_state_e state_d;
    logic       match_q;
    logic       match_d;

    // Next state and match; clear wins over enable
    always_comb begin
        state_d = state_q;
        match_d = 1'b0;
        if (clr) begin
            state_d = S0;
        end else if (en) begin
            match_d = (state_q == LAST_S) && !bit_in;
            case (state_q)
                S0:      state_d = bit_in ? S1 : S0;
                S1:      state_d = bit_in ? S1 : S2;
                S2:      state_d = bit_in ? S3 : S0;
                S3:      state_d = bit_in ? S4 : S2;
                S4:      state_d = bit_in ? S1 : S2;
                default: state_d = S0;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and match registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
        end
    end

    assign match = match_q;
    assign state = state_q;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Word-to-bit sequencer around pattern_det_core, returning per-word match counts.
// Optional running total enabled by defining PATTERN_SCAN_TOTAL_EN.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    pattern_scan_ctrl_if.slave  bus,
    output logic                busy,
    output logic [2:0]          det_state,
    output logic [15:0]         total_count
);

    localparam int BC_W = $clog2(WORD_W + 1);

    ctrl_state_e       state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;
    logic              out_hit_q, out_hit_d;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              det_en_s;
    logic              det_clr_s;
    logic              det_bit_s;
    logic              det_match_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != {CNT_W{1'b1}})) begin
            return v + CNT_W'(1);
        end else begin
            return v;
        end
    endfunction

    pattern_det_core u_core (
        .clk    (clk),
        .reset  (reset),
        .en     (det_en_s),
        .clr    (det_clr_s),
        .bit_in (det_bit_s),
        .match  (det_match_s),
        .state  (det_state)
    );

    assign cnt_inc_s = sat_inc(cnt_q, det_match_s);

    // Controller next state, datapath updates and detector controls
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        cnt_d       = cnt_q;
        out_count_d = out_count_q;
        out_hit_d   = out_hit_q;
        det_en_s    = 1'b0;
        det_clr_s   = 1'b0;
        det_bit_s   = shreg_q[WORD_W-1];
        case (state_q)
            IDLE: begin
                // Flush lands on the same edge as a load, so the first bit sees S0
                det_clr_s = bus.flush;
                if (bus.in_valid) begin
                    shreg_d  = bus.in_data;
                    bitcnt_d = BC_W'(WORD_W);
                    cnt_d    = {CNT_W{1'b0}};
                    state_d  = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                det_en_s = 1'b1;
                shreg_d  = shreg_q << 1;
                bitcnt_d = bitcnt_q - BC_W'(1);
                cnt_d    = cnt_inc_s;
                if (bitcnt_q == BC_W'(1)) begin
                    state_d = DRAIN;
                end else begin
                    state_d = SHIFT;
                end
            end
            DRAIN: begin
                cnt_d       = cnt_inc_s;
                out_count_d = cnt_inc_s;
                out_hit_d   = (cnt_inc_s != {CNT_W{1'b0}});
                state_d     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shreg_q     <= {WORD_W{1'b0}};
            bitcnt_q    <= {BC_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            out_count_q <= {CNT_W{1'b0}};
            out_hit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            cnt_q       <= cnt_d;
            out_count_q <= out_count_d;
            out_hit_q   <= out_hit_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_count = out_count_q;
    assign bus.out_hit   = out_hit_q;
    assign busy          = (state_q != IDLE);

`ifdef PATTERN_SCAN_TOTAL_EN
    logic [15:0] total_q, total_d;

    // Saturating running total of every match; only reset clears it
    always_comb begin
        if (det_match_s && (total_q != 16'hFFFF)) begin
            total_d = total_q + 16'd1;
        end else begin
            total_d = total_q;
        end
    end

    // Running total register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_q <= 16'h0000;
        end else begin
            total_q <= total_d;
        end
    end

    assign total_count = total_q;
`else
    assign total_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Randomized self-checking bench for pattern_scan_ctrl: a CNT_W=4 and a CNT_W=1
// instance run in lockstep against a bit-history reference model.
module tb_pattern_scan_ctrl;

    localparam int WORD_W = 8;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pattern_scan_ctrl_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus_a ();
    pattern_scan_ctrl_if #(.WORD_W(WORD_W), .CNT_W(1))     bus_b ();

    logic        busy_a, busy_b;
    logic [2:0]  det_state_a, det_state_b;
    logic [15:0] total_a, total_b;

    pattern_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_a),
        .busy        (busy_a),
        .det_state   (det_state_a),
        .total_count (total_a)
    );

    pattern_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(1)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_b),
        .busy        (busy_b),
        .det_state   (det_state_b),
        .total_count (total_b)
    );

    int         n_vec = 0;
    int         n_err = 0;
    bit         hist[$];
    int         model_total;
    logic [4:0] pat_v = 5'b10110;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: detector state = longest history suffix (<5) that is a pattern prefix
    function automatic int model_state();
        bit ok;
        for (int k = 4; k >= 1; k--) begin
            if (hist.size() >= k) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (hist[hist.size() - k + j] != pat_v[4 - j]) ok = 1'b0;
                end
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    task automatic model_word(input logic [WORD_W-1:0] w, output int m);
        bit ok;
        m = 0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            hist.push_back(w[i]);
            if (hist.size() > 5) void'(hist.pop_front());
            if (hist.size() == 5) begin
                ok = 1'b1;
                for (int j = 0; j < 5; j++) begin
                    if (hist[j] != pat_v[4 - j]) ok = 1'b0;
                end
                if (ok) m++;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [WORD_W-1:0] d, input logic f, input logic r);
        bus_a.in_valid = v; bus_a.in_data = d; bus_a.flush = f; bus_a.out_ready = r;
        bus_b.in_valid = v; bus_b.in_data = d; bus_b.flush = f; bus_b.out_ready = r;
    endtask

    task automatic check_idle_reset_values(input string tag);
        chk({tag, "_busy"},      busy_a,          32'd0);
        chk({tag, "_in_ready"},  bus_a.in_ready,  32'd1);
        chk({tag, "_out_valid"}, bus_a.out_valid, 32'd0);
        chk({tag, "_out_count"}, bus_a.out_count, 32'd0);
        chk({tag, "_out_hit"},   bus_a.out_hit,   32'd0);
        chk({tag, "_det_state"}, det_state_a,     32'd0);
        chk({tag, "_total"},     total_a,         32'd0);
        chk({tag, "_b_count"},   bus_b.out_count, 32'd0);
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        hist.delete();
        model_total = 0;
        @(negedge clk);
        check_idle_reset_values("reset");
        reset = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        drive(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, '0, 1'b0, 1'b0);
        hist.delete();
        @(negedge clk);
        chk("flush_det_state", det_state_a, 32'd0);
    endtask

    // One word end to end: handshake, latency, result, backpressure, release
    task automatic run_word(input logic [WORD_W-1:0] w, input bit fl, input int stall, input bit noise);
        int m, lat, exp_a, exp_b, exp_tot;
        @(negedge clk);
        chk("in_ready_idle", bus_a.in_ready, 32'd1);
        drive(1'b1, w, fl, 1'b0);
        if (fl) hist.delete();
        model_word(w, m);
        model_total = (model_total + m > 65535) ? 65535 : model_total + m;
        exp_a = (m > 15) ? 15 : m;
        exp_b = (m > 1) ? 1 : m;
`ifdef PATTERN_SCAN_TOTAL_EN
        exp_tot = model_total;
`else
        exp_tot = 0;
`endif
        @(posedge clk);
        #1;
        drive(1'b0, '0, 1'b0, 1'b0);
        lat = 1;
        @(negedge clk);
        while (!bus_a.out_valid && lat < 40) begin
            if (noise) drive($urandom_range(0, 1), WORD_W'($urandom), $urandom_range(0, 1), 1'b0);
            @(negedge clk);
            lat++;
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("latency",      lat,             WORD_W + 2);
        chk("out_count",    bus_a.out_count, exp_a);
        chk("out_hit",      bus_a.out_hit,   (m != 0) ? 32'd1 : 32'd0);
        chk("det_state",    det_state_a,     model_state());
        chk("total_count",  total_a,         exp_tot);
        chk("b_out_count",  bus_b.out_count, exp_b);
        chk("b_out_valid",  bus_b.out_valid, 32'd1);
        chk("in_ready_done", bus_a.in_ready, 32'd0);
        chk("busy_done",    busy_a,          32'd1);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_out_valid", bus_a.out_valid, 32'd1);
            chk("stall_out_count", bus_a.out_count, exp_a);
            chk("stall_in_ready",  bus_a.in_ready,  32'd0);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("taken_out_valid", bus_a.out_valid, 32'd0);
        chk("taken_in_ready",  bus_a.in_ready,  32'd1);
        chk("held_out_count",  bus_a.out_count, exp_a);
    endtask

    task automatic reset_mid_shift(input logic [WORD_W-1:0] w);
        @(negedge clk);
        drive(1'b1, w, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("pre_abort_busy", busy_a, 32'd1);
        #1;
        reset = 1'b1;
        hist.delete();
        model_total = 0;
        #1;
        check_idle_reset_values("abort");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [WORD_W-1:0] w;
        reset = 1'b1;
        model_total = 0;
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        do_reset();

        run_word(8'b10110110, 1'b0, 0, 1'b0);
        do_reset();
        run_word(8'h00, 1'b0, 0, 1'b0);

        do_reset();
        run_word(8'b00000101, 1'b0, 0, 1'b0);
        run_word(8'b10000000, 1'b0, 3, 1'b0);
        do_reset();
        run_word(8'b00000101, 1'b0, 0, 1'b0);
        do_flush();
        run_word(8'b10000000, 1'b0, 0, 1'b0);
        run_word(8'b00000101, 1'b0, 0, 1'b0);
        run_word(8'b10000000, 1'b1, 1, 1'b0);

        do_reset();
        run_word(8'b10110110, 1'b0, 0, 1'b0);
        run_word(8'b10110110, 1'b0, 0, 1'b0);

        reset_mid_shift(8'b10110110);
        run_word(8'b11111111, 1'b0, 0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       w = 8'b10110110;
                1:       w = {3'b101, 5'(($urandom_range(0, 1) != 0) ? 5'b10110 : 5'b10101)};
                default: w = WORD_W'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0) do_flush();
            run_word(w, ($urandom_range(0, 5) == 0), $urandom_range(0, 3), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
